// File: rtl/netfpga_pkg.sv
// Shared types for the NetFPGA clocking/reset sequencer: state encoding,
// counter widths and a saturating event-counter helper.
package netfpga_pkg;

  localparam int CNT_W = 16;
  localparam int EVT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [EVT_W-1:0] evt_t;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  typedef struct packed {
    logic dcm_rst;
    logic sys_rst;
    logic ready;
  } seq_out_t;

  function automatic evt_t sat_inc(input evt_t v, input logic en);
    return (en && (v != {EVT_W{1'b1}})) ? v + evt_t'(1) : v;
  endfunction

endpackage

// File: rtl/netfpga_sync2.sv
// Two-flop level synchronizer with async active-low reset; reset value 0.
module netfpga_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/netfpga_rst_seq.sv
// MMCM reset/lock sequencer: pulses DCM_RST, waits for a stable synchronized
// lock, then releases SYS_RST; retries on timeout and restarts on lock loss.
module netfpga_rst_seq
  import netfpga_pkg::*;
#(
  parameter int RST_CYCLES    = 255,
  parameter int LOCK_TIMEOUT  = 20000,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic             CLK200,
  input  logic             RST_N,
  input  logic             DCM_LOCKED,
  input  logic             REINIT,
  output logic             DCM_RST,
  output logic             SYS_RST,
  output logic             READY,
  output logic [EVT_W-1:0] RETRY_CNT,
  output logic [EVT_W-1:0] LOSS_CNT
);

  // Limits are "last cycle in state" values so each state lasts exactly N cycles.
  localparam cnt_t RST_LIM = cnt_t'(RST_CYCLES - 1);
  localparam cnt_t TO_LIM  = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t STB_LIM = cnt_t'(STABLE_CYCLES - 1);
  localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

  logic     lock_s;
  state_t   state, nxt;
  cnt_t     cnt;
  logic     clr, inc_retry, inc_loss;
  seq_out_t out_d;

  netfpga_sync2 #(.W(1)) u_lock_sync (
    .clk   (CLK200),
    .rst_n (RST_N),
    .d     (DCM_LOCKED),
    .q     (lock_s)
  );

  // State, shared cycle counter and event counts
  always_ff @(posedge CLK200 or negedge RST_N) begin
    if (!RST_N) begin
      state     <= PLL_RST;
      cnt       <= '0;
      RETRY_CNT <= '0;
      LOSS_CNT  <= '0;
    end else begin
      state     <= nxt;
      cnt       <= clr ? '0 : ((cnt == CNT_MAX) ? cnt : cnt + cnt_t'(1));
      RETRY_CNT <= sat_inc(RETRY_CNT, inc_retry);
      LOSS_CNT  <= sat_inc(LOSS_CNT, inc_loss);
    end
  end

  // Next state; REINIT overrides every other event and never counts
  always_comb begin
    nxt       = state;
    clr       = 1'b0;
    inc_retry = 1'b0;
    inc_loss  = 1'b0;
    if (REINIT) begin
      nxt = PLL_RST;
      clr = 1'b1;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt >= RST_LIM) begin
            nxt = WAIT_LOCK;
            clr = 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            nxt = STABLE;
            clr = 1'b1;
          end else if (cnt >= TO_LIM) begin
            nxt       = PLL_RST;
            clr       = 1'b1;
            inc_retry = 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            nxt = WAIT_LOCK;
            clr = 1'b1;
          end else if (cnt >= STB_LIM) begin
            nxt = RUN;
            clr = 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            nxt      = PLL_RST;
            clr      = 1'b1;
            inc_loss = 1'b1;
          end
        end
        default: begin
          nxt = PLL_RST;
          clr = 1'b1;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so the registers track the state flop
  always_comb begin
    out_d.dcm_rst = (nxt == PLL_RST);
    out_d.sys_rst = (nxt != RUN);
    out_d.ready   = (nxt == RUN);
  end

  always_ff @(posedge CLK200 or negedge RST_N) begin
    if (!RST_N) begin
      DCM_RST <= 1'b1;
      SYS_RST <= 1'b1;
      READY   <= 1'b0;
    end else begin
      DCM_RST <= out_d.dcm_rst;
      SYS_RST <= out_d.sys_rst;
      READY   <= out_d.ready;
    end
  end

endmodule

// File: tb/tb_netfpga_rst_seq.sv
// Directed bench for netfpga_rst_seq with RST_CYCLES=4, LOCK_TIMEOUT=16,
// STABLE_CYCLES=8; inputs change and outputs are sampled 1ns after posedge.
module tb_netfpga_rst_seq;

  logic       CLK200 = 1'b0;
  logic       RST_N = 1'b0;
  logic       DCM_LOCKED = 1'b0;
  logic       REINIT = 1'b0;
  logic       DCM_RST, SYS_RST, READY;
  logic [7:0] RETRY_CNT, LOSS_CNT;
  int         total = 0;
  int         bad = 0;

  always #5 CLK200 = ~CLK200;

  netfpga_rst_seq #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (16),
    .STABLE_CYCLES (8)
  ) dut (
    .CLK200     (CLK200),
    .RST_N      (RST_N),
    .DCM_LOCKED (DCM_LOCKED),
    .REINIT     (REINIT),
    .DCM_RST    (DCM_RST),
    .SYS_RST    (SYS_RST),
    .READY      (READY),
    .RETRY_CNT  (RETRY_CNT),
    .LOSS_CNT   (LOSS_CNT)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK200);
    #1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; DCM_LOCKED = 1'b1;
    cyc(3);
    total++; if (DCM_RST !== 1'b1) begin bad++; $display("FAIL reset_dcm_rst got=%b want=1", DCM_RST); end
    total++; if (SYS_RST !== 1'b1) begin bad++; $display("FAIL reset_sys_rst got=%b want=1", SYS_RST); end
    total++; if (READY !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", READY); end
    total++; if (RETRY_CNT !== 8'd0) begin bad++; $display("FAIL reset_retry got=%0d want=0", RETRY_CNT); end
    total++; if (LOSS_CNT !== 8'd0) begin bad++; $display("FAIL reset_loss got=%0d want=0", LOSS_CNT); end
    DCM_LOCKED = 1'b0;
    cyc(1);
  endtask

  task automatic test_bringup;
    RST_N = 1'b1;
    total++; if (DCM_RST !== 1'b1) begin bad++; $display("FAIL bringup_dcm_rst_c0 got=%b want=1", DCM_RST); end
    for (int i = 1; i <= 3; i++) begin
      cyc(1);
      total++; if (DCM_RST !== 1'b1) begin bad++; $display("FAIL bringup_dcm_rst_c%0d got=%b want=1", i, DCM_RST); end
    end
    cyc(1);
    total++; if (DCM_RST !== 1'b0) begin bad++; $display("FAIL bringup_dcm_rst_drop got=%b want=0", DCM_RST); end
    total++; if (SYS_RST !== 1'b1) begin bad++; $display("FAIL bringup_sys_rst_wait got=%b want=1", SYS_RST); end
    cyc(10);
    DCM_LOCKED = 1'b1;
    cyc(10);
    total++; if (READY !== 1'b0) begin bad++; $display("FAIL bringup_ready_early got=%b want=0", READY); end
    cyc(1);
    total++; if (READY !== 1'b1) begin bad++; $display("FAIL bringup_ready got=%b want=1", READY); end
    total++; if (SYS_RST !== 1'b0) begin bad++; $display("FAIL bringup_sys_rst got=%b want=0", SYS_RST); end
    total++; if (RETRY_CNT !== 8'd0 || LOSS_CNT !== 8'd0) begin bad++; $display("FAIL bringup_counts got=%0d/%0d want=0/0", RETRY_CNT, LOSS_CNT); end
  endtask

  task automatic test_loss;
    DCM_LOCKED = 1'b0;
    cyc(2);
    total++; if (SYS_RST !== 1'b0) begin bad++; $display("FAIL loss_sys_rst_early got=%b want=0", SYS_RST); end
    cyc(1);
    total++; if (SYS_RST !== 1'b1 || READY !== 1'b0) begin bad++; $display("FAIL loss_sys_rst got=%b/%b want=1/0", SYS_RST, READY); end
    total++; if (LOSS_CNT !== 8'd1) begin bad++; $display("FAIL loss_cnt got=%0d want=1", LOSS_CNT); end
    total++; if (DCM_RST !== 1'b1) begin bad++; $display("FAIL loss_dcm_rst got=%b want=1", DCM_RST); end
    cyc(3);
    total++; if (DCM_RST !== 1'b1) begin bad++; $display("FAIL loss_dcm_rst_c4 got=%b want=1", DCM_RST); end
    cyc(1);
    total++; if (DCM_RST !== 1'b0) begin bad++; $display("FAIL loss_dcm_rst_drop got=%b want=0", DCM_RST); end
    DCM_LOCKED = 1'b1;
    cyc(11);
    total++; if (READY !== 1'b1 || LOSS_CNT !== 8'd1 || RETRY_CNT !== 8'd0) begin bad++; $display("FAIL loss_recover got=%b/%0d/%0d want=1/1/0", READY, LOSS_CNT, RETRY_CNT); end
  endtask

  task automatic test_glitch;
    REINIT = 1'b1;
    cyc(1);
    REINIT = 1'b0;
    total++; if (DCM_RST !== 1'b1 || LOSS_CNT !== 8'd1) begin bad++; $display("FAIL glitch_reinit got=%b/%0d want=1/1", DCM_RST, LOSS_CNT); end
    cyc(9);
    DCM_LOCKED = 1'b0;
    cyc(3);
    DCM_LOCKED = 1'b1;
    total++; if (DCM_RST !== 1'b0 || READY !== 1'b0) begin bad++; $display("FAIL glitch_wait got=%b/%b want=0/0", DCM_RST, READY); end
    cyc(1);
    total++; if (DCM_RST !== 1'b0 || READY !== 1'b0) begin bad++; $display("FAIL glitch_hold got=%b/%b want=0/0", DCM_RST, READY); end
    cyc(9);
    total++; if (READY !== 1'b0) begin bad++; $display("FAIL glitch_window_early got=%b want=0", READY); end
    cyc(1);
    total++; if (READY !== 1'b1) begin bad++; $display("FAIL glitch_window got=%b want=1", READY); end
    total++; if (RETRY_CNT !== 8'd0 || LOSS_CNT !== 8'd1) begin bad++; $display("FAIL glitch_counts got=%0d/%0d want=0/1", RETRY_CNT, LOSS_CNT); end
  endtask

  task automatic test_no_lock;
    REINIT = 1'b1; DCM_LOCKED = 1'b0;
    for (int k = 1; k <= 101; k++) begin
      cyc(1);
      if (k == 1) begin
        REINIT = 1'b0;
        total++; if (LOSS_CNT !== 8'd1) begin bad++; $display("FAIL nolock_loss got=%0d want=1", LOSS_CNT); end
      end
      total++; if (READY !== 1'b0) begin bad++; $display("FAIL nolock_ready_k%0d got=%b want=0", k, READY); end
      if (k == 20 || k == 21 || k == 40 || k == 41 || k == 100 || k == 101) begin
        total++; if (RETRY_CNT !== 8'((k - 1) / 20)) begin bad++; $display("FAIL nolock_retry_k%0d got=%0d want=%0d", k, RETRY_CNT, (k - 1) / 20); end
      end
      if (k == 1 || k == 21 || k == 24) begin
        total++; if (DCM_RST !== 1'b1) begin bad++; $display("FAIL nolock_dcm_hi_k%0d got=%b want=1", k, DCM_RST); end
      end
      if (k == 20 || k == 25) begin
        total++; if (DCM_RST !== 1'b0) begin bad++; $display("FAIL nolock_dcm_lo_k%0d got=%b want=0", k, DCM_RST); end
      end
    end
  endtask

  task automatic test_reinit_priority;
    DCM_LOCKED = 1'b1;
    cyc(13);
    total++; if (READY !== 1'b1) begin bad++; $display("FAIL prio_run got=%b want=1", READY); end
    DCM_LOCKED = 1'b0;
    cyc(2);
    REINIT = 1'b1;
    cyc(1);
    REINIT = 1'b0;
    total++; if (DCM_RST !== 1'b1 || SYS_RST !== 1'b1) begin bad++; $display("FAIL prio_pll_rst got=%b/%b want=1/1", DCM_RST, SYS_RST); end
    total++; if (LOSS_CNT !== 8'd1 || RETRY_CNT !== 8'd5) begin bad++; $display("FAIL prio_counts got=%0d/%0d want=1/5", LOSS_CNT, RETRY_CNT); end
    cyc(20 * 249);
    total++; if (RETRY_CNT !== 8'd254) begin bad++; $display("FAIL sat_retry_254 got=%0d want=254", RETRY_CNT); end
    cyc(20);
    total++; if (RETRY_CNT !== 8'd255) begin bad++; $display("FAIL sat_retry_255 got=%0d want=255", RETRY_CNT); end
    cyc(1000);
    total++; if (RETRY_CNT !== 8'd255) begin bad++; $display("FAIL sat_retry_hold got=%0d want=255", RETRY_CNT); end
  endtask

  task automatic test_async_reset;
    DCM_LOCKED = 1'b1;
    cyc(40);
    total++; if (READY !== 1'b1) begin bad++; $display("FAIL areset_pre_run got=%b want=1", READY); end
    #3;
    RST_N = 1'b0;
    #1;
    total++; if (SYS_RST !== 1'b1 || DCM_RST !== 1'b1 || READY !== 1'b0) begin bad++; $display("FAIL areset_outs got=%b/%b/%b want=1/1/0", SYS_RST, DCM_RST, READY); end
    total++; if (RETRY_CNT !== 8'd0 || LOSS_CNT !== 8'd0) begin bad++; $display("FAIL areset_counts got=%0d/%0d want=0/0", RETRY_CNT, LOSS_CNT); end
    cyc(1);
    RST_N = 1'b1;
    cyc(3);
    total++; if (DCM_RST !== 1'b1) begin bad++; $display("FAIL areset_restart_dcm got=%b want=1", DCM_RST); end
    cyc(1);
    total++; if (DCM_RST !== 1'b0) begin bad++; $display("FAIL areset_restart_drop got=%b want=0", DCM_RST); end
    cyc(8);
    total++; if (READY !== 1'b0) begin bad++; $display("FAIL areset_ready_early got=%b want=0", READY); end
    cyc(1);
    total++; if (READY !== 1'b1) begin bad++; $display("FAIL areset_ready got=%b want=1", READY); end
  endtask

  initial begin
    #1;
    test_reset;
    test_bringup;
    test_loss;
    test_glitch;
    test_no_lock;
    test_reinit_priority;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/netfpga_rst_seq.md
NETFPGA_RST_SEQ -- requirements
Module: netfpga_rst_seq

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 255, which sets the number of cycles DCM_RST is held high per reset attempt (range 1..65535).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 20000, which sets the cycles allowed in WAIT_LOCK before a retry (range 1..65535).
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 1024, which sets the consecutive synchronized-lock cycles required before release (range 1..65535).
REQ-004 The block SHALL have port CLK200, input, width 1, which is the sole clock; every flop is clocked by it.
REQ-005 The block SHALL have port RST_N, input, width 1, which is an asynchronous, active-low reset.
REQ-006 The block SHALL have port DCM_LOCKED, input, width 1, which is the MMCM lock and is asynchronous to CLK200.
REQ-007 The block SHALL have port REINIT, input, width 1, which is a single-cycle request to restart the sequence.
REQ-008 The block SHALL have port DCM_RST, output, width 1, which is an active-high reset to the MMCM.
REQ-009 The block SHALL have port SYS_RST, output, width 1, which is an active-high reset for downstream logic.
REQ-010 The block SHALL have port READY, output, width 1, which is high only in RUN.
REQ-011 The block SHALL have port RETRY_CNT, output, width 8, which counts lock timeouts and saturates at 255.
REQ-012 The block SHALL have port LOSS_CNT, output, width 8, which counts losses of lock in RUN and saturates at 255.

Function
REQ-013 DCM_LOCKED SHALL pass through a 2-flop synchronizer, giving lock_s; no other logic SHALL sample the raw DCM_LOCKED.
REQ-014 The state machine SHALL have the states PLL_RST, WAIT_LOCK, STABLE and RUN, and SHALL share one 16-bit cycle counter that clears on every state entry.
REQ-015 In PLL_RST, DCM_RST SHALL be 1; after exactly RST_CYCLES cycles in the state, the machine SHALL go to WAIT_LOCK.
REQ-016 In WAIT_LOCK, DCM_RST SHALL be 0; lock_s=1 SHALL cause a move to STABLE; if the counter reaches LOCK_TIMEOUT with lock_s=0, the machine SHALL go to PLL_RST and increment RETRY_CNT.
REQ-017 In STABLE, after STABLE_CYCLES consecutive cycles of lock_s=1, the machine SHALL go to RUN; any lock_s=0 SHALL cause a return to WAIT_LOCK with the counter cleared and no count incremented.
REQ-018 In RUN, lock_s=0 SHALL cause a move to PLL_RST and increment LOSS_CNT.
REQ-019 SYS_RST SHALL be 1 in every state except RUN; READY SHALL be the exact complement of SYS_RST.
REQ-020 All outputs SHALL be registered: each output SHALL reflect the new state in the cycle after the transition edge, and SYS_RST SHALL rise one cycle after the loss edge.
REQ-021 REINIT=1 in any state SHALL force PLL_RST and SHALL take priority over every simultaneous event; no count SHALL increment on a REINIT-caused transition.
REQ-022 REINIT while already in PLL_RST SHALL restart the RST_CYCLES count.
REQ-023 Both counts SHALL hold at 255 once saturated, and SHALL clear only on RST_N.
REQ-024 Parameter comparisons SHALL use 16-bit unsigned arithmetic, and the counter SHALL never wrap within a state.

Reset
REQ-025 While RST_N=0, the block SHALL force state=PLL_RST, counter=0, DCM_RST=1, SYS_RST=1, READY=0, RETRY_CNT=0, LOSS_CNT=0, and synchronizer flops=0.
REQ-026 Assertion of RST_N=0 mid-operation, including in RUN, SHALL take effect immediately and asynchronously; after release, the full sequence SHALL restart from PLL_RST with count 0.

Structure
REQ-027 The state encoding, the 16-bit counter width, and the 8-bit count width SHALL be defined in the shared package netfpga_pkg.
REQ-028 The synchronizer SHALL be the sub-module netfpga_sync2, a 2-flop synchronizer with asynchronous active-low reset, shared with other clock-crossing uses.

Verification
(Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8.)
REQ-029 Clean bring-up: release RST_N with DCM_LOCKED rising 10 cycles later -> DCM_RST high for 4 cycles, then READY=1 and SYS_RST=0 at cycle 10+2+8+1 after WAIT_LOCK entry; both counts = 0.
REQ-030 No lock: hold DCM_LOCKED=0 for 100 cycles -> RETRY_CNT increments every 4+16 cycles and DCM_RST pulses 4 cycles each retry; READY stays 0.
REQ-031 Glitch in STABLE: drop DCM_LOCKED for 3 cycles after 5 stable cycles -> the machine returns to WAIT_LOCK, DCM_RST stays 0, no count changes, and a fresh 8-cycle window is required.
REQ-032 Loss in RUN: drop DCM_LOCKED in RUN -> SYS_RST=1 three cycles later (2 sync + 1 register), LOSS_CNT=1, DCM_RST=1 for 4 cycles, then recovery.
REQ-033 REINIT priority: pulse REINIT in the same cycle as a lock loss in RUN -> PLL_RST is entered and LOSS_CNT is unchanged; force 300 timeouts -> RETRY_CNT holds at 255.
REQ-034 Asynchronous reset: assert RST_N=0 mid-RUN between clock edges -> SYS_RST=1, DCM_RST=1 and both counts 0 before the next edge.
